// File: rtl/mem_arbiter_if.sv
// Halfword beat bus between mem_arbiter (master) and mem_interface (slave).
// ack marks the cycle in which a beat is accepted and rdata is valid.
interface mem_arbiter_if #(
    parameter int unsigned HADDR_W = 18
);
    logic               req;
    logic               we;
    logic [HADDR_W-1:0] addr;
    logic [15:0]        wdata;
    logic               ub;
    logic               lb;
    logic               ack;
    logic [15:0]        rdata;

    modport master (output req, we, addr, wdata, ub, lb, input ack, rdata);
    modport slave (input req, we, addr, wdata, ub, lb, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Non-preemptive arbiter sharing one 16-bit SRAM port between fetch, memory stage and, when
// VGA_PORT_EN is defined, the VGA reader; 32-bit byte accesses are split into halfword beats.
module mem_arbiter #(
    parameter int unsigned HADDR_W       = 18,
    parameter int unsigned VGA_PRIO_HIGH = 1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               f_req,
    input  logic [31:0]        f_addr,
    output logic [31:0]        f_rdata,
    output logic               f_done,
    output logic               f_blocked,
    input  logic               m_req,
    input  logic               m_we,
    input  logic [31:0]        m_addr,
    input  logic [31:0]        m_wdata,
    output logic [31:0]        m_rdata,
    output logic               m_done,
    output logic               m_blocked,
`ifdef VGA_PORT_EN
    input  logic               v_req,
    input  logic [HADDR_W-1:0] v_addr,
    output logic [15:0]        v_rdata,
    output logic               v_done,
`endif
    mem_arbiter_if.master      mi
);
    typedef enum logic [1:0] {StIdle, StAccess, StComplete} state_e;
    typedef enum logic [1:0] {OwnF, OwnM, OwnV} owner_e;

    typedef struct packed {
        logic [HADDR_W-1:0] addr;
        logic [15:0]        data;
        logic               ub;
        logic               lb;
    } beat_t;

    state_e             state_q;
    owner_e             owner_q;
    logic [HADDR_W-1:0] base_q;
    logic               odd_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic [1:0]         beat_q;
    logic [1:0]         last_q;
    logic [15:0]        rd0_q;
    logic [15:0]        rd1_q;

    logic               vga_req;
    logic [HADDR_W-1:0] vga_addr;
`ifdef VGA_PORT_EN
    assign vga_req  = v_req;
    assign vga_addr = v_addr;
`else
    assign vga_req  = 1'b0;
    assign vga_addr = '0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:HADDR_W+1], m_addr[31:HADDR_W+1]};

    assign f_blocked = f_req & ~f_done;
    assign m_blocked = m_req & ~m_done;

    logic               gnt;
    owner_e             gnt_owner;
    logic [HADDR_W-1:0] gnt_base;
    logic               gnt_odd;
    logic               gnt_we;
    logic [31:0]        gnt_wdata;
    logic [1:0]         gnt_last;

    always_comb begin
        gnt       = 1'b1;
        gnt_owner = OwnF;
        gnt_base  = f_addr[HADDR_W:1];
        gnt_odd   = f_addr[0];
        gnt_we    = 1'b0;
        gnt_wdata = '0;
        if (vga_req && VGA_PRIO_HIGH != 0) begin
            gnt_owner = OwnV;
            gnt_base  = vga_addr;
            gnt_odd   = 1'b0;
        end else if (m_req) begin
            gnt_owner = OwnM;
            gnt_base  = m_addr[HADDR_W:1];
            gnt_odd   = m_addr[0];
            gnt_we    = m_we;
            gnt_wdata = m_wdata;
        end else if (f_req) begin
            gnt_owner = OwnF;
        end else if (vga_req) begin
            gnt_owner = OwnV;
            gnt_base  = vga_addr;
            gnt_odd   = 1'b0;
        end else begin
            gnt = 1'b0;
        end
        gnt_last = (gnt_owner == OwnV) ? 2'd0 : (gnt_odd ? 2'd2 : 2'd1);
    end

    // Odd writes mask the byte outside the word at the two edge beats; reads use both lanes.
    function automatic beat_t plan(input logic [HADDR_W-1:0] base, input logic odd,
                                   input logic we, input logic [31:0] wdata,
                                   input logic [1:0] idx);
        beat_t b;
        b.addr = base + HADDR_W'(idx);
        b.ub   = 1'b1;
        b.lb   = 1'b1;
        if (!odd) begin
            b.data = idx[0] ? wdata[31:16] : wdata[15:0];
        end else begin
            unique case (idx)
                2'd0: begin
                    b.data = {wdata[7:0], 8'h00};
                    b.lb   = ~we;
                end
                2'd1: b.data = wdata[23:8];
                default: begin
                    b.data = {8'h00, wdata[31:24]};
                    b.ub   = ~we;
                end
            endcase
        end
        return b;
    endfunction

    beat_t       first_beat;
    beat_t       next_beat;
    logic [31:0] read32;
    assign first_beat = plan(gnt_base, gnt_odd, gnt_we, gnt_wdata, 2'd0);
    assign next_beat  = plan(base_q, odd_q, we_q, wdata_q, beat_q + 2'd1);
    assign read32     = odd_q ? {mi.rdata[7:0], rd1_q, rd0_q[15:8]} : {mi.rdata, rd0_q};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= OwnF;
            base_q   <= '0;
            odd_q    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            beat_q   <= '0;
            last_q   <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
            f_done   <= 1'b0;
            f_rdata  <= '0;
            m_done   <= 1'b0;
            m_rdata  <= '0;
            mi.req   <= 1'b0;
            mi.we    <= 1'b0;
            mi.addr  <= '0;
            mi.wdata <= '0;
            mi.ub    <= 1'b0;
            mi.lb    <= 1'b0;
`ifdef VGA_PORT_EN
            v_done   <= 1'b0;
            v_rdata  <= '0;
`endif
        end else begin
            f_done <= 1'b0;
            m_done <= 1'b0;
`ifdef VGA_PORT_EN
            v_done <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (gnt) begin
                        owner_q  <= gnt_owner;
                        base_q   <= gnt_base;
                        odd_q    <= gnt_odd;
                        we_q     <= gnt_we;
                        wdata_q  <= gnt_wdata;
                        last_q   <= gnt_last;
                        beat_q   <= 2'd0;
                        mi.req   <= 1'b1;
                        mi.we    <= gnt_we;
                        mi.addr  <= first_beat.addr;
                        mi.wdata <= first_beat.data;
                        mi.ub    <= first_beat.ub;
                        mi.lb    <= first_beat.lb;
                        state_q  <= StAccess;
                    end
                end
                StAccess: begin
                    if (mi.ack) begin
                        if (beat_q == 2'd0) rd0_q <= mi.rdata;
                        if (beat_q == 2'd1) rd1_q <= mi.rdata;
                        if (beat_q == last_q) begin
                            mi.req  <= 1'b0;
                            mi.we   <= 1'b0;
                            state_q <= StComplete;
                            unique case (owner_q)
                                OwnF: begin
                                    f_done  <= 1'b1;
                                    f_rdata <= read32;
                                end
                                OwnM: begin
                                    m_done <= 1'b1;
                                    if (!we_q) m_rdata <= read32;
                                end
                                default: begin
`ifdef VGA_PORT_EN
                                    v_done  <= 1'b1;
                                    v_rdata <= mi.rdata;
`endif
                                end
                            endcase
                        end else begin
                            beat_q   <= beat_q + 2'd1;
                            mi.addr  <= next_beat.addr;
                            mi.wdata <= next_beat.data;
                            mi.ub    <= next_beat.ub;
                            mi.lb    <= next_beat.lb;
                        end
                    end
                end
                StComplete: state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural SRAM slave with random ack delays and a byte-addressed
// reference memory that predicts every 32-bit read and write.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int unsigned HADDR_W = 18;
    localparam int unsigned HWORDS  = 1 << HADDR_W;
    localparam int unsigned BYTES   = 2 * HWORDS;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic [31:0] f_rdata;
    logic        f_done;
    logic        f_blocked;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_done;
    logic        m_blocked;
`ifdef VGA_PORT_EN
    logic               v_req;
    logic [HADDR_W-1:0] v_addr;
    logic [15:0]        v_rdata;
    logic               v_done;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.HADDR_W(HADDR_W)) mi ();

    mem_arbiter #(.HADDR_W(HADDR_W), .VGA_PRIO_HIGH(1)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_done    (f_done),
        .f_blocked (f_blocked),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_done    (m_done),
        .m_blocked (m_blocked),
`ifdef VGA_PORT_EN
        .v_req     (v_req),
        .v_addr    (v_addr),
        .v_rdata   (v_rdata),
        .v_done    (v_done),
`endif
        .mi        (mi)
    );

    // SRAM slave model
    logic [15:0]  sram    [0:HWORDS-1];
    logic [7:0]   ref_mem [0:BYTES-1];
    int unsigned  ack_wait = 0;
    int unsigned  ack_max  = 0;
    bit           ack_hold = 1'b0;

    typedef struct {
        logic [HADDR_W-1:0] addr;
        logic               we;
        logic               ub;
        logic               lb;
        logic [15:0]        data;
    } beat_t;
    beat_t beats[$];

    assign mi.ack   = mi.req && !ack_hold && (ack_wait == 0);
    assign mi.rdata = sram[mi.addr];

    always @(posedge clk) begin
        if (mi.req && mi.ack) begin
            beats.push_back('{mi.addr, mi.we, mi.ub, mi.lb, mi.wdata});
            if (mi.we && mi.ub) sram[mi.addr][15:8] <= mi.wdata[15:8];
            if (mi.we && mi.lb) sram[mi.addr][7:0] <= mi.wdata[7:0];
            ack_wait <= $urandom_range(ack_max);
        end else if (mi.req && ack_wait != 0) begin
            ack_wait <= ack_wait - 1;
        end
    end

    function automatic logic [31:0] ref_rd32(input int unsigned a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_mem[(a + i) % BYTES];
        return r;
    endfunction

    function automatic void ref_wr32(input int unsigned a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) ref_mem[(a + i) % BYTES] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] sram_rd32(input int unsigned a);
        logic [31:0] r;
        int unsigned b;
        for (int i = 0; i < 4; i++) begin
            b = (a + i) % BYTES;
            r[8*i +: 8] = b[0] ? sram[b >> 1][15:8] : sram[b >> 1][7:0];
        end
        return r;
    endfunction

    task automatic poke(input int unsigned h, input logic [15:0] v);
        sram[h] <= v;
        ref_mem[2*h]     = v[7:0];
        ref_mem[2*h + 1] = v[15:8];
    endtask

    task automatic run_fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
        beats.delete();
        f_addr = a;
        f_req  = 1'b1;
        lat    = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (f_done) begin
                lat = c;
                break;
            end
        end
        d     = f_rdata;
        f_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_mem(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] d, output int lat);
        beats.delete();
        m_we    = we;
        m_addr  = a;
        m_wdata = wd;
        m_req   = 1'b1;
        lat     = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (m_done) begin
                lat = c;
                break;
            end
        end
        d     = m_rdata;
        m_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({f_done, m_done, mi.req, mi.we, mi.ub, mi.lb} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {f_done, m_done, mi.req, mi.we, mi.ub, mi.lb});
        end
        total++;
        if ({f_rdata, m_rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h want 0", {f_rdata, m_rdata});
        end
        total++;
        if ({mi.addr, mi.wdata} !== '0) begin
            bad++;
            $display("FAIL reset_bus: got addr %h wdata %h want 0", mi.addr, mi.wdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_even_fetch();
        logic [31:0] d;
        int lat;
        poke(8, 16'h1234);
        poke(9, 16'hABCD);
        @(negedge clk);
        run_fetch(32'h10, d, lat);
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL even_fetch_latency: got %0d want 3", lat);
        end
        total++;
        if (d !== 32'hABCD1234) begin
            bad++;
            $display("FAIL even_fetch_data: got %h want abcd1234", d);
        end
        total++;
        if (beats.size() !== 2) begin
            bad++;
            $display("FAIL even_fetch_beats: got %0d want 2", beats.size());
        end else begin
            total++;
            if ({beats[0].addr, beats[1].addr, beats[0].we, beats[1].we}
                !== {18'h8, 18'h9, 2'b00}) begin
                bad++;
                $display("FAIL even_fetch_addr: got %h,%h we %b%b want 8,9 we 00",
                         beats[0].addr, beats[1].addr, beats[0].we, beats[1].we);
            end
        end
    endtask

    task automatic test_odd_write();
        logic [31:0] d;
        int lat;
        run_mem(1'b1, 32'h21, 32'hAABBCCDD, d, lat);
        ref_wr32(32'h21, 32'hAABBCCDD);
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL odd_write_latency: got %0d want 4", lat);
        end
        total++;
        if (beats.size() !== 3) begin
            bad++;
            $display("FAIL odd_write_beats: got %0d want 3", beats.size());
        end else begin
            total++;
            if ({beats[0].addr, beats[0].we, beats[0].ub, beats[0].lb, beats[0].data[15:8]}
                !== {18'h10, 3'b110, 8'hDD}) begin
                bad++;
                $display("FAIL odd_write_beat0: got a=%h we/ub/lb=%b%b%b d=%h want 10 110 dd",
                         beats[0].addr, beats[0].we, beats[0].ub, beats[0].lb, beats[0].data);
            end
            total++;
            if ({beats[1].addr, beats[1].we, beats[1].ub, beats[1].lb, beats[1].data}
                !== {18'h11, 3'b111, 16'hBBCC}) begin
                bad++;
                $display("FAIL odd_write_beat1: got a=%h we/ub/lb=%b%b%b d=%h want 11 111 bbcc",
                         beats[1].addr, beats[1].we, beats[1].ub, beats[1].lb, beats[1].data);
            end
            total++;
            if ({beats[2].addr, beats[2].we, beats[2].ub, beats[2].lb, beats[2].data[7:0]}
                !== {18'h12, 3'b101, 8'hAA}) begin
                bad++;
                $display("FAIL odd_write_beat2: got a=%h we/ub/lb=%b%b%b d=%h want 12 101 aa",
                         beats[2].addr, beats[2].we, beats[2].ub, beats[2].lb, beats[2].data);
            end
        end
        total++;
        if ({sram[16'h10], sram[16'h11], sram[16'h12]} !==
            {ref_mem[33], ref_mem[32], ref_mem[35], ref_mem[34], ref_mem[37], ref_mem[36]}) begin
            bad++;
            $display("FAIL odd_write_sram: got %h %h %h want %h%h %h%h %h%h",
                     sram[16'h10], sram[16'h11], sram[16'h12], ref_mem[33], ref_mem[32],
                     ref_mem[35], ref_mem[34], ref_mem[37], ref_mem[36]);
        end
        total++;
        if (m_done !== 1'b0) begin
            bad++;
            $display("FAIL odd_write_single_pulse: got m_done %b want 0", m_done);
        end
    endtask

    task automatic test_priority();
        int m_cyc = -1;
        int f_cyc = -1;
        int blk_err = 0;
        logic [31:0] f_d = '0;
        logic [31:0] m_d = '0;
        f_addr = 32'h40;
        f_req  = 1'b1;
        m_addr = 32'h80;
        m_we   = 1'b0;
        m_req  = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (m_done) begin
                m_cyc = c;
                m_d   = m_rdata;
                m_req = 1'b0;
            end
            if (f_done) begin
                f_cyc = c;
                f_d   = f_rdata;
                if (f_blocked !== 1'b0) blk_err++;
                f_req = 1'b0;
                break;
            end else if (f_blocked !== 1'b1) begin
                blk_err++;
            end
        end
        f_req = 1'b0;
        m_req = 1'b0;
        @(negedge clk);
        total++;
        if ({m_cyc, f_cyc} !== {32'sd3, 32'sd7}) begin
            bad++;
            $display("FAIL priority_order: got m_done@%0d f_done@%0d want 3 and 7", m_cyc, f_cyc);
        end
        total++;
        if (blk_err !== 0) begin
            bad++;
            $display("FAIL priority_f_blocked: got %0d bad cycles want 0", blk_err);
        end
        total++;
        if ({m_d, f_d} !== {ref_rd32(32'h80), ref_rd32(32'h40)}) begin
            bad++;
            $display("FAIL priority_data: got m %h f %h want %h %h",
                     m_d, f_d, ref_rd32(32'h80), ref_rd32(32'h40));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int lat;
        run_fetch(32'h7FFFF, d, lat);
        total++;
        if (beats.size() !== 3) begin
            bad++;
            $display("FAIL wrap_beats: got %0d want 3", beats.size());
        end else begin
            total++;
            if ({beats[0].addr, beats[1].addr, beats[2].addr} !== {18'h3FFFF, 18'h0, 18'h1}) begin
                bad++;
                $display("FAIL wrap_addr: got %h %h %h want 3ffff 00000 00001",
                         beats[0].addr, beats[1].addr, beats[2].addr);
            end
        end
        total++;
        if ({lat, d} !== {32'sd4, ref_rd32(32'h7FFFF)}) begin
            bad++;
            $display("FAIL wrap_data: got lat %0d data %h want 4 %h", lat, d, ref_rd32(32'h7FFFF));
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        int lat;
        int pulses = 0;
        bit seen = 1'b0;
        ack_hold = 1'b1;
        f_addr   = 32'h100;
        f_req    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mi.req) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("FAIL abort_mi_req_rise: got %b want 1", seen);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        f_req = 1'b0;
        @(negedge clk);
        total++;
        if ({mi.req, f_done} !== 2'b00) begin
            bad++;
            $display("FAIL abort_mi_req: got req/done %b want 00", {mi.req, f_done});
        end
        total++;
        if (f_rdata !== 32'h0) begin
            bad++;
            $display("FAIL abort_rdata_clear: got %h want 0", f_rdata);
        end
        reset    = 1'b0;
        ack_hold = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (f_done || m_done || mi.req) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", pulses);
        end
        run_fetch(32'h102, d, lat);
        total++;
        if ({lat, d} !== {32'sd3, ref_rd32(32'h102)}) begin
            bad++;
            $display("FAIL abort_recover: got lat %0d data %h want 3 %h", lat, d, ref_rd32(32'h102));
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] wd;
        int unsigned a;
        int unsigned kind;
        int lat;
        int nwe;
        ack_max = 3;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(2);
            a    = ($urandom_range(3) == 0) ? BYTES - 1 - $urandom_range(6) : $urandom_range(127);
            wd   = $urandom;
            if (kind == 0) run_fetch(a, d, lat);
            else run_mem(kind == 2, a, wd, d, lat);
            nwe = 0;
            foreach (beats[i]) if (beats[i].we) nwe++;
            total++;
            if ({beats.size(), nwe} !== {(a % 2 == 1) ? 3 : 2, (kind == 2) ? ((a % 2 == 1) ? 3 : 2) : 0}) begin
                bad++;
                $display("FAIL random_beats: kind %0d addr %h got %0d beats %0d writes", kind, a,
                         beats.size(), nwe);
            end
            if (kind == 2) begin
                ref_wr32(a, wd);
                total++;
                if (sram_rd32(a) !== ref_rd32(a) || lat < 0) begin
                    bad++;
                    $display("FAIL random_write: addr %h got %h want %h lat %0d", a, sram_rd32(a),
                             ref_rd32(a), lat);
                end
            end else begin
                total++;
                if (d !== ref_rd32(a) || lat < 0) begin
                    bad++;
                    $display("FAIL random_read: kind %0d addr %h got %h want %h lat %0d", kind, a, d,
                             ref_rd32(a), lat);
                end
            end
        end
        ack_max = 0;
        repeat (4) @(negedge clk);
    endtask

`ifdef VGA_PORT_EN
    task automatic test_vga();
        int f_cyc = -1;
        int v_cyc = -1;
        logic [31:0] f_d = '0;
        logic [15:0] v_d = '0;
        f_addr = 32'h30;
        f_req  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                v_addr = 18'h155;
                v_req  = 1'b1;
            end
            if (f_done) begin
                f_cyc = c;
                f_d   = f_rdata;
                f_req = 1'b0;
            end
            if (v_done) begin
                v_cyc = c;
                v_d   = v_rdata;
                v_req = 1'b0;
                break;
            end
        end
        v_req = 1'b0;
        f_req = 1'b0;
        @(negedge clk);
        total++;
        if ({f_cyc, v_cyc} !== {32'sd3, 32'sd6}) begin
            bad++;
            $display("FAIL vga_order: got f_done@%0d v_done@%0d want 3 and 6", f_cyc, v_cyc);
        end
        total++;
        if ({f_d, v_d} !== {ref_rd32(32'h30), ref_mem[18'h155 * 2 + 1], ref_mem[18'h155 * 2]}) begin
            bad++;
            $display("FAIL vga_data: got f %h v %h want %h %h%h", f_d, v_d, ref_rd32(32'h30),
                     ref_mem[18'h155 * 2 + 1], ref_mem[18'h155 * 2]);
        end
    endtask
`endif

    initial begin
        logic [7:0] lo;
        logic [7:0] hi;
        reset   = 1'b1;
        f_req   = 1'b0;
        f_addr  = '0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
`ifdef VGA_PORT_EN
        v_req   = 1'b0;
        v_addr  = '0;
`endif
        for (int h = 0; h < HWORDS; h++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            poke(h, {hi, lo});
        end
        test_reset();
        test_even_fetch();
        test_odd_write();
        test_priority();
        test_wrap();
        test_reset_abort();
`ifdef VGA_PORT_EN
        test_vga();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
